// File: rtl/ee201_button_conditioner.sv
// Two-channel push-button conditioner for the numlock FSM: each channel
// synchronises, debounces and strobes one raw button.

module ee201_button_channel #(
    parameter int DB_COUNT = 10,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw,
    output logic       db,
    output logic       pulse,
    output logic [4:0] state
);

    typedef enum logic [4:0] {
        INI   = 5'b00001,
        WQ    = 5'b00010,
        PULSE = 5'b00100,
        HELD  = 5'b01000,
        WR    = 5'b10000
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_COUNT - 1);

    state_t           st;
    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    // db/pulse are registered alongside the state so they always match it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            st    <= INI;
            db    <= 1'b0;
            pulse <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            pulse <= 1'b0;
            case (st)
                INI: begin
                    db <= 1'b0;
                    if (s2) begin
                        st  <= WQ;
                        cnt <= '0;
                    end
                end
                WQ: begin
                    db <= 1'b0;
                    if (!s2) begin
                        st  <= INI;
                        cnt <= '0;
                    end else if (cnt == LAST) begin
                        st    <= PULSE;
                        db    <= 1'b1;
                        pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PULSE: begin
                    st <= HELD;
                    db <= 1'b1;
                end
                HELD: begin
                    db <= 1'b1;
                    if (!s2) begin
                        st  <= WR;
                        cnt <= '0;
                    end
                end
                WR: begin
                    db <= 1'b1;
                    if (s2) begin
                        st  <= HELD;
                        cnt <= '0;
                    end else if (cnt == LAST) begin
                        st <= INI;
                        db <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    st  <= INI;
                    cnt <= '0;
                    db  <= 1'b0;
                end
            endcase
        end
    end

    assign state = st;

endmodule

module ee201_button_conditioner #(
    parameter int DB_COUNT = 10,
    parameter int CNT_W    = 4
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       U_raw,
    input  logic       Z_raw,
    output logic       U_db,
    output logic       Z_db,
    output logic       U_pulse,
    output logic       Z_pulse,
    output logic [4:0] U_state,
    output logic [4:0] Z_state
);

    ee201_button_channel #(
        .DB_COUNT(DB_COUNT),
        .CNT_W   (CNT_W)
    ) u_chan (
        .clk  (Clk),
        .reset(reset),
        .raw  (U_raw),
        .db   (U_db),
        .pulse(U_pulse),
        .state(U_state)
    );

    ee201_button_channel #(
        .DB_COUNT(DB_COUNT),
        .CNT_W   (CNT_W)
    ) z_chan (
        .clk  (Clk),
        .reset(reset),
        .raw  (Z_raw),
        .db   (Z_db),
        .pulse(Z_pulse),
        .state(Z_state)
    );

endmodule

// File: doc/ee201_button_conditioner.md
Name: ee201_button_conditioner

Overview:
- Conditions the two raw push-button inputs for the numlock state machine.
- Per channel: synchronises the asynchronous button, debounces it with a counter-qualified FSM, and produces two outputs.
  - A clean level (U_db / Z_db), which drives the numlock U / Z inputs.
  - A one-clock pulse on each qualified press (U_pulse / Z_pulse).
- Sits directly upstream of the numlock state machine, between the board buttons and the lock.

Parameters:
- DB_COUNT, 10: cycles of stable input needed to qualify a press or a release. Legal range is DB_COUNT >= 2.
- CNT_W, 4: debounce counter width. Must satisfy 2^CNT_W >= DB_COUNT.

Ports:
- Clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- U_raw  input  1  raw U button, asynchronous to Clk, active-high.
- Z_raw  input  1  raw Z button, asynchronous to Clk, active-high.
- U_db  output  1  debounced U level, feeds numlock U.
- Z_db  output  1  debounced Z level, feeds numlock Z.
- U_pulse  output  1  single-cycle strobe on a qualified U press.
- Z_pulse  output  1  single-cycle strobe on a qualified Z press.
- U_state  output  5  one-hot U-channel state, for display/debug.
- Z_state  output  5  one-hot Z-channel state, for display/debug.

Behaviour:
- Two identical, fully independent channels; the U channel is described here.
- Synchroniser: 2-flop chain U_raw -> s1 -> s2. The FSM uses s2 only.
- Counter: cnt[CNT_W-1:0].
- State encoding is one-hot, 5 bits, bit order {WR, HELD, PULSE, WQ, INI}.
- INI (00001): U_db=0, U_pulse=0.
  - s2=1 -> WQ, cnt<=0.
  - Otherwise stay.
- WQ (00010), wait-qualify press: outputs 0.
  - s2=0 -> INI, cnt<=0.
  - s2=1 and cnt==DB_COUNT-1 -> PULSE.
  - Otherwise cnt<=cnt+1.
- PULSE (00100): U_db=1, U_pulse=1, for exactly one cycle.
  - Unconditionally -> HELD.
- HELD (01000): U_db=1, U_pulse=0.
  - s2=0 -> WR, cnt<=0.
  - Otherwise stay.
- WR (10000), wait-qualify release: U_db=1, U_pulse=0.
  - s2=1 -> HELD, cnt<=0.
  - s2=0 and cnt==DB_COUNT-1 -> INI.
  - Otherwise cnt<=cnt+1.
- Outputs are Moore outputs, decoded from the state register only. There is no combinational path from the raw input to any output.
- Latency: U_raw held stable high from edge 0 -> U_db=1 and U_pulse=1 after edge DB_COUNT+2. That is 12 edges after edge 0 for DB_COUNT=10. Release latency is identical, so U_db=0 after edge DB_COUNT+2.
- Boundary cases:
  - Glitch rejection: a high run shorter than DB_COUNT+1 cycles at s2 never asserts U_db. Any low during WQ restarts qualification from INI.
  - Release bounce: any high at s2 during WR returns the FSM to HELD. U_db stays 1 throughout and no new pulse is issued.
  - Held button: exactly one U_pulse per press, no auto-repeat, regardless of hold length.
  - Simultaneous U and Z presses: the channels are independent, so both pulses may assert in the same cycle. There is no arbitration; the numlock resolves U&Z itself.
  - Counter: only compared against DB_COUNT-1, so it never wraps. It is cleared on every entry to WQ or WR.
- Reset (reset=0, asynchronous):
  - Effect: s1=s2=0, cnt=0, state=INI.
  - Output values while reset is asserted: U_db=Z_db=0, U_pulse=Z_pulse=0, U_state=Z_state=5'b00001.
  - Reset applied mid-operation (any state) forces these values immediately, without waiting for a Clk edge.
  - After release with the button still pressed: full press qualification is required before a new pulse.
- Illegal or non-one-hot state codes -> INI on the next edge.

Test Plan:
- Glitch-free press: DB_COUNT=10; reset pulse, then U_raw=1 held 40 cycles -> U_db rises after edge 12, U_pulse=1 for exactly that one cycle. U_state walks 00001->00010->00100->01000. Z outputs stay 0.
- Glitch rejection: U_raw=1 for 8 cycles then 0 -> U_db and U_pulse never assert; U_state returns to 00001.
- Release bounce: from HELD, U_raw low 5 cycles, high 3 cycles, then low 30 cycles -> U_db stays 1 through the bounce and falls after edge 12 of the final low run. No second pulse.
- Simultaneous press: U_raw and Z_raw rise in the same cycle -> U_pulse and Z_pulse assert in the same cycle, 12 edges later.
- Reset mid-release: in WR, drive reset=0 between edges -> all outputs 0 immediately. Release reset with U_raw=1 -> a new pulse after edge 12 following release.
- Long hold: U_raw=1 for 1000 cycles -> exactly one U_pulse. U_db=1 from edge 12 to the end of the hold.
